dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 16K-word data RAM between two requesters.
- Port 0 is the CPU load/store path. Port 1 is the UART program/data loader, or any future DMA-style master.
- Port 0 has fixed priority. A starvation counter guarantees port 1 forward progress.
- Sits between the requesters and the RAM. It drives the RAM's write enable, word address and write data, and returns read data with a one-cycle latency tag.

Parameters:
- ADDR_W, 14, RAM word-address width; the RAM address is taken from byte address bits [ADDR_W+1:2].
- STARVE_LIMIT, 8, consecutive denied cycles of p1_req after which port 1 is forced to win (legal range 1..255).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request, sampled each cycle.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_gnt  out  1  port 0 access accepted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid (registered, one cycle after grant).
- p0_rdata  out  32  port 0 read data (equals mem_rdata).
- p0_err  out  1  port 0 misaligned access flag (registered pulse).
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same directions, widths and meanings as port 0, for port 1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- State machine, two states:
  - PRIO0 (reset state): port 0 wins whenever p0_req=1.
  - FORCE1: port 1 wins whenever p1_req=1.
- State transitions:
  - PRIO0 -> FORCE1 when starve_cnt == STARVE_LIMIT.
  - FORCE1 -> PRIO0 after any cycle in which p1_gnt=1, or in which p1_req=0 (request withdrawn).
- Grant (combinational):
  - Exactly one of p0_gnt/p1_gnt is high when the winner's req=1.
  - Both grants are low when neither port requests.
  - The loser sees gnt=0 and must hold its request and operands stable until granted.
- RAM drive (combinational):
  - mem_addr = winner_addr[ADDR_W+1:2].
  - mem_wdata = winner_wdata.
  - mem_we = winner_gnt & winner_we & aligned.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Alignment:
  - aligned = (addr[1:0]==2'b00). A misaligned access is still granted and consumes its cycle.
  - Misaligned write: mem_we is suppressed.
  - Misaligned read: rvalid is still returned, with unspecified data.
  - pX_err pulses high for one cycle, the cycle after the grant.
- Read return:
  - A registered tag records {port, read} at each grant.
  - In the next cycle, pX_rvalid=1 for the tagged port only.
  - p0_rdata = p1_rdata = mem_rdata at all times.
  - Back-to-back grants to alternating ports are legal; each rvalid follows its own grant by exactly one cycle.
- starve_cnt (8 bits):
  - Increments when p1_req=1 and p1_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on p1_gnt=1 or p1_req=0.
- Writes: complete at the grant edge; no write acknowledge beyond the grant.
- Reset (synchronous, takes priority over all updates):
  - state=PRIO0, starve_cnt=0.
  - Read tag cleared, so p0_rvalid=p1_rvalid=0 and p0_err=p1_err=0 in the cycle after reset is sampled.
  - A read granted in the same cycle reset is asserted never produces rvalid.
  - Combinational outputs follow inputs even during reset; mem_we is forced to 0 while reset=1.
- Simultaneous requests in FORCE1 with p1_req=0: port 0 is granted that cycle, and the state returns to PRIO0.

Test Plan:
- Port 0 only: p0 write 0xDEADBEEF @0x00000010, then read @0x10 -> mem_addr=4 and mem_we=1 in cycle 0; p0_rvalid=1 with p0_rdata=0xDEADBEEF one cycle after the read grant.
- Contention, STARVE_LIMIT=8: p0_req and p1_req held high continuously -> p0 granted 8 cycles, p1 granted on the 9th, pattern repeats (8:1); no cycle with both grants.
- Interleaved reads: p0 read @0x20 in cycle N, p1 read @0x24 in cycle N+1 (p0_req dropped) -> p0_rvalid in N+1 only, p1_rvalid in N+2 only, each carrying its own word.
- Misaligned: p1 write @0x00000006 data 0x12345678 -> p1_gnt=1, mem_we=0, p1_err=1 next cycle; a subsequent aligned read @0x4 returns the prior contents, unchanged.
- Reset mid-operation: p0 read granted in the same cycle reset=1 -> no p0_rvalid next cycle; starve_cnt at 5 returns to 0 and the state is PRIO0 (p1 needs 8 more denied cycles before it is forced).
- FORCE1 withdrawal: reach FORCE1, then drop p1_req with p0_req=1 -> p0_gnt=1 that cycle, state PRIO0 next cycle, starve_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Request/grant bus between the two data-RAM requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view. The master modport is the requester/RAM side.
interface dmem_arbiter_if #(parameter int ADDR_W = 14);
  logic              p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [31:0]       p0_addr, p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0]       p1_addr, p1_wdata, p1_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM. Port 0 has fixed priority.
// A starvation counter forces port 1 through after STARVE_LIMIT consecutive denials.
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  typedef enum logic {PRIO0, FORCE1} state_t;

  state_t          state;
  logic [7:0]      starve_cnt, cnt_nxt;
  logic [1:0]      req, we, gnt, mis, rvalid, err;
  logic [1:0][31:0] addr, wdata;
  logic            win;

  assign req   = {bus.p1_req,   bus.p0_req};
  assign we    = {bus.p1_we,    bus.p0_we};
  assign addr  = {bus.p1_addr,  bus.p0_addr};
  assign wdata = {bus.p1_wdata, bus.p0_wdata};
  assign mis   = {|bus.p1_addr[1:0], |bus.p0_addr[1:0]};

  always_comb begin
    win = (state == FORCE1) ? req[1] : ~req[0];
    gnt = '0;
    gnt[win] = req[win];
    bus.mem_we    = gnt[win] & we[win] & ~mis[win] & ~reset;
    bus.mem_addr  = gnt[win] ? addr[win][ADDR_W+1:2] : '0;
    bus.mem_wdata = gnt[win] ? wdata[win] : '0;
    if (!req[1] || gnt[1])   cnt_nxt = '0;
    else if (starve_cnt >= LIM) cnt_nxt = LIM;
    else                      cnt_nxt = starve_cnt + 8'd1;
  end

  // Switching on the edge where the count reaches the limit gives exactly
  // STARVE_LIMIT denials before the forced grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= PRIO0;
      starve_cnt <= '0;
      rvalid     <= '0;
      err        <= '0;
    end else begin
      starve_cnt <= cnt_nxt;
      rvalid     <= gnt & ~we;
      err        <= gnt & mis;
      case (state)
        PRIO0:   if (cnt_nxt == LIM) state <= FORCE1;
        FORCE1:  if (gnt[1] || !req[1]) state <= PRIO0;
        default: state <= PRIO0;
      endcase
    end
  end

  assign bus.p0_gnt    = gnt[0];
  assign bus.p1_gnt    = gnt[1];
  assign bus.p0_rvalid = rvalid[0];
  assign bus.p1_rvalid = rvalid[1];
  assign bus.p0_err    = err[0];
  assign bus.p1_err    = err[1];
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

  logic unused_addr;
  assign unused_addr = ^{bus.p0_addr[31:ADDR_W+2], bus.p1_addr[31:ADDR_W+2]};
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table plus contention, reset and withdrawal sequences.
// The bench holds a behavioural model of the RAM with one cycle of read latency.
module tb_dmem_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dmem_arbiter_if #(.ADDR_W(14)) bus();
  dmem_arbiter #(.ADDR_W(14), .STARVE_LIMIT(8)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  logic [31:0] ram [0:16383];
  initial for (int i = 0; i < 16384; i++) ram[i] = '0;
  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_in(input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
    reset = rst;
    bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
    bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic rst; logic r0, w0; logic [31:0] a0, d0; logic r1, w1; logic [31:0] a1, d1;
    logic g0, g1, we; logic [13:0] ma;
    logic rv0, rv1, er0, er1; logic chk_rd; logic [31:0] rd;
  } vec_t;

  vec_t v [$];

  // Both ports issue reads; grant pattern is checked against the expected forced slots.
  task automatic contend(input string tag, input int n, input int forced_a, input int forced_b,
                         input logic first_rv0);
    logic prev0, prev1, e1;
    prev0 = first_rv0; prev1 = 1'b0;
    for (int k = 0; k < n; k++) begin
      set_in(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
      e1 = (k == forced_a) || (k == forced_b);
      @(negedge clock);
      chk($sformatf("%s_g0_%0d", tag, k), {31'd0, bus.p0_gnt}, {31'd0, ~e1});
      chk($sformatf("%s_g1_%0d", tag, k), {31'd0, bus.p1_gnt}, {31'd0, e1});
      chk($sformatf("%s_rv0_%0d", tag, k), {31'd0, bus.p0_rvalid}, {31'd0, prev0});
      chk($sformatf("%s_rv1_%0d", tag, k), {31'd0, bus.p1_rvalid}, {31'd0, prev1});
      if (prev0) chk($sformatf("%s_rd0_%0d", tag, k), bus.p0_rdata, 32'hDEADBEEF);
      if (prev1) chk($sformatf("%s_rd1_%0d", tag, k), bus.p1_rdata, 32'h11111111);
      prev0 = ~e1; prev1 = e1;
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        rst r0 w0 a0     d0            r1 w1 a1     d1            g0 g1 we ma  rv0 rv1 er0 er1 chk rd
    v.push_back('{0, 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0,14'd0,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 1,1,32'h10,32'hDEADBEEF, 0,0,32'h0, 32'h0,        1,0,1,14'd4,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 1,0,32'h10,32'h0,        0,0,32'h0, 32'h0,        1,0,0,14'd4,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0,14'd0,  1,0,0,0, 1,32'hDEADBEEF});
    v.push_back('{0, 1,1,32'h20,32'h11111111, 0,0,32'h0, 32'h0,        1,0,1,14'd8,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 1,1,32'h24,32'h22222222, 0,0,32'h0, 32'h0,        1,0,1,14'd9,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 1,0,32'h20,32'h0,        0,0,32'h0, 32'h0,        1,0,0,14'd8,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        1,0,32'h24,32'h0,        0,1,0,14'd9,  1,0,0,0, 1,32'h11111111});
    v.push_back('{0, 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0,14'd0,  0,1,0,0, 1,32'h22222222});
    v.push_back('{0, 1,1,32'h4, 32'hCAFEF00D, 0,0,32'h0, 32'h0,        1,0,1,14'd1,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        1,1,32'h6, 32'h12345678, 0,1,0,14'd1,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        1,0,32'h4, 32'h0,        0,1,0,14'd1,  0,0,0,1, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0,14'd0,  0,1,0,0, 1,32'hCAFEF00D});
    v.push_back('{0, 1,0,32'h11,32'h0,        0,0,32'h0, 32'h0,        1,0,0,14'd4,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0,14'd0,  1,0,1,0, 0,32'h0});
    v.push_back('{0, 1,0,32'h10,32'h0,        1,0,32'h20,32'h0,        1,0,0,14'd4,  0,0,0,0, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        1,0,32'h20,32'h0,        0,1,0,14'd8,  1,0,0,0, 1,32'hDEADBEEF});
    v.push_back('{0, 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0,14'd0,  0,1,0,0, 1,32'h11111111});
    v.push_back('{1, 1,1,32'h30,32'h55,       0,0,32'h0, 32'h0,        1,0,0,14'd12, 0,0,0,0, 0,32'h0});
    v.push_back('{0, 1,0,32'h30,32'h0,        0,0,32'h0, 32'h0,        1,0,0,14'd12, 0,0,0,0, 0,32'h0});
    v.push_back('{0, 0,0,32'h0, 32'h0,        0,0,32'h0, 32'h0,        0,0,0,14'd0,  1,0,0,0, 1,32'h0});

    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;

    foreach (v[i]) begin
      set_in(v[i].rst, v[i].r0, v[i].w0, v[i].a0, v[i].d0, v[i].r1, v[i].w1, v[i].a1, v[i].d1);
      @(negedge clock);
      chk($sformatf("v%0d_g0", i),  {31'd0, bus.p0_gnt},    {31'd0, v[i].g0});
      chk($sformatf("v%0d_g1", i),  {31'd0, bus.p1_gnt},    {31'd0, v[i].g1});
      chk($sformatf("v%0d_we", i),  {31'd0, bus.mem_we},    {31'd0, v[i].we});
      chk($sformatf("v%0d_ma", i),  {18'd0, bus.mem_addr},  {18'd0, v[i].ma});
      chk($sformatf("v%0d_rv0", i), {31'd0, bus.p0_rvalid}, {31'd0, v[i].rv0});
      chk($sformatf("v%0d_rv1", i), {31'd0, bus.p1_rvalid}, {31'd0, v[i].rv1});
      chk($sformatf("v%0d_er0", i), {31'd0, bus.p0_err},    {31'd0, v[i].er0});
      chk($sformatf("v%0d_er1", i), {31'd0, bus.p1_err},    {31'd0, v[i].er1});
      if (v[i].chk_rd) begin
        chk($sformatf("v%0d_rd0", i), bus.p0_rdata, v[i].rd);
        chk($sformatf("v%0d_rd1", i), bus.p1_rdata, v[i].rd);
      end
      next_cycle();
    end

    // Continuous contention: 8 grants to port 0, then one forced grant to port 1, repeating.
    contend("cont", 18, 8, 17, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Reset with the starvation count at 5 and a port-0 read granted in the reset cycle.
    contend("pre_rst", 5, -1, -1, 1'b0);
    set_in(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
    @(negedge clock);
    chk("rst_cycle_g0", {31'd0, bus.p0_gnt}, 32'd1);
    chk("rst_cycle_we", {31'd0, bus.mem_we}, 32'd0);
    next_cycle();
    contend("post_rst", 9, 8, -1, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Reach FORCE1, then withdraw port 1 while port 0 requests.
    contend("pre_wd", 8, -1, -1, 1'b0);
    set_in(0, 1, 0, 32'h10, 0, 0, 0, 32'h20, 0);
    @(negedge clock);
    chk("wd_g0", {31'd0, bus.p0_gnt}, 32'd1);
    chk("wd_g1", {31'd0, bus.p1_gnt}, 32'd0);
    next_cycle();
    contend("post_wd", 9, 8, -1, 1'b1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
